fetch_unit: RTL and testbench

//   Requester side of the i_cache read port. Holds the fetch PC and issues one

---
 rtl/fetch_unit.sv | 108 ++++++++++
 tb/tb_fetch_unit.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Fetch unit: drives the i_cache read port one address per cycle and buffers
// the returned {instruction, pc} pairs in a small FIFO feeding decode.
module fetch_unit #(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter int unsigned QUEUE_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        ic_rd_en,
  output logic [15:0] ic_rd_dest,
  input  logic [15:0] ic_rd_out,
  input  logic [15:0] ic_pc_out,
  input  logic        halt,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [15:0] dec_instr,
  output logic [15:0] dec_pc
);

  localparam int unsigned PTR_W  = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned CRED_W = CNT_W + 1;

  logic [15:0]      fetch_pc;
  logic             inflight;
  logic             squash;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic [15:0]      q_instr [QUEUE_DEPTH];
  logic [15:0]      q_pc    [QUEUE_DEPTH];

  logic              push;
  logic              pop;
  logic [CRED_W-1:0] credit_used;

  // Credit counts queued entries plus the one response still in flight.
  assign credit_used = CRED_W'(count) + CRED_W'(inflight);

  // Strobe is held low while in reset so the first read follows reset release.
  assign ic_rd_en   = rst_n & ~halt & ~redirect_valid &
                      (credit_used < CRED_W'(QUEUE_DEPTH));
  assign ic_rd_dest = fetch_pc;

  assign push      = inflight & ~squash;
  assign dec_valid = (count != '0);
  assign pop       = dec_valid & dec_ready;
  assign dec_instr = q_instr[rd_ptr];
  assign dec_pc    = q_pc[rd_ptr];

  // Fetch PC, in-flight and squash tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
      inflight <= 1'b0;
      squash   <= 1'b0;
    end else begin
      squash   <= redirect_valid;
      inflight <= ic_rd_en;
      if (redirect_valid) begin
        fetch_pc <= redirect_pc;
      end else if (ic_rd_en) begin
        fetch_pc <= fetch_pc + 16'd1;
      end
    end
  end

  // Queue pointers and occupancy; a redirect flush overrides push and pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (redirect_valid) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Queue storage; the response is captured from the i_cache outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < QUEUE_DEPTH; i++) begin
        q_instr[i] <= 16'h0000;
        q_pc[i]    <= 16'h0000;
      end
    end else if (push && !redirect_valid) begin
      q_instr[wr_ptr] <= ic_rd_out;
      q_pc[wr_ptr]    <= ic_pc_out;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: i_cache model with mem[a] = a + 16'h1000,
// directed scenarios, and a scoreboard of expected decode pcs.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ic_rd_en;
  logic [15:0] ic_rd_dest;
  logic [15:0] ic_rd_out = 16'h0000;
  logic [15:0] ic_pc_out = 16'h0000;
  logic        halt = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic        dec_valid;
  logic        dec_ready = 1'b0;
  logic [15:0] dec_instr;
  logic [15:0] dec_pc;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];
  logic [15:0] wrap_seq [4];

  fetch_unit #(.RESET_PC(16'h0000), .QUEUE_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .ic_rd_en(ic_rd_en), .ic_rd_dest(ic_rd_dest),
    .ic_rd_out(ic_rd_out), .ic_pc_out(ic_pc_out),
    .halt(halt), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_instr(dec_instr), .dec_pc(dec_pc)
  );

  always #5 clk = ~clk;

  // 1-cycle-latency i_cache model
  always @(posedge clk) begin
    if (ic_rd_en) begin
      ic_rd_out <= ic_rd_dest + 16'h1000;
      ic_pc_out <= ic_rd_dest;
    end
  end

  // Scoreboard monitor: every decode handshake must match the next expected pc
  always @(negedge clk) begin
    logic [15:0] e;
    if (rst_n && dec_valid && dec_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pop: got pc %h instr %h, none expected", dec_pc, dec_instr);
      end else begin
        e = exp_q.pop_front();
        if (dec_pc !== e || dec_instr !== (e + 16'h1000)) begin
          errors++;
          $display("FAIL pop: got pc %h instr %h, want pc %h instr %h",
                   dec_pc, dec_instr, e, e + 16'h1000);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic push_range(input logic [15:0] first, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(first + 16'(i));
  endtask

  task automatic do_reset(input logic ready);
    rst_n = 1'b0;
    halt = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 16'h0000;
    dec_ready = ready;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_dec_valid", 32'(dec_valid), 32'd0);
    chk("rst_rd_en", 32'(ic_rd_en), 32'd0);
    chk("rst_dec_pc", 32'(dec_pc), 32'h0);
    chk("rst_dec_instr", 32'(dec_instr), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Wait (bounded) for all expected entries to be delivered, then confirm idle
  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(posedge clk);
      n++;
    end
    chk({name, "_drained_left"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk({name, "_idle_valid"}, 32'(dec_valid), 32'd0);
    next_cycle();
  endtask

  initial begin
    wrap_seq[0] = 16'hFFFE;
    wrap_seq[1] = 16'hFFFF;
    wrap_seq[2] = 16'h0000;
    wrap_seq[3] = 16'h0001;

    // Streaming from reset, then halt at rd_dest 8 and resume
    do_reset(1'b1);
    push_range(16'h0000, 8);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("s1_rd_en", 32'(ic_rd_en), 32'd1);
      chk("s1_rd_dest", 32'(ic_rd_dest), 32'(k));
      if (k >= 2) chk("s1_dec_valid", 32'(dec_valid), 32'd1);
      next_cycle();
    end
    halt = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("s5_halt_rd_en", 32'(ic_rd_en), 32'd0);
      if (k == 4) chk("s5_drained", 32'(dec_valid), 32'd0);
      next_cycle();
    end
    halt = 1'b0;
    push_range(16'h0008, 6);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("s5_resume_en", 32'(ic_rd_en), 32'd1);
      chk("s5_resume_dest", 32'(ic_rd_dest), 32'(8 + k));
      next_cycle();
    end
    halt = 1'b1;
    drain("s5");

    // Backpressure from reset: exactly 4 strobes, then credit returns late
    do_reset(1'b0);
    push_range(16'h0000, 8);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k < 4) begin
        chk("s2_rd_en", 32'(ic_rd_en), 32'd1);
        chk("s2_rd_dest", 32'(ic_rd_dest), 32'(k));
      end else begin
        chk("s2_stall_en", 32'(ic_rd_en), 32'd0);
      end
      if (k == 9) begin
        chk("s2_head_valid", 32'(dec_valid), 32'd1);
        chk("s2_head_pc", 32'(dec_pc), 32'h0);
      end
      next_cycle();
    end
    dec_ready = 1'b1;
    @(negedge clk);
    chk("s2_pop_no_credit", 32'(ic_rd_en), 32'd0);
    next_cycle();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("s2_resume_en", 32'(ic_rd_en), 32'd1);
      chk("s2_resume_dest", 32'(ic_rd_dest), 32'(4 + k));
      next_cycle();
    end
    halt = 1'b1;
    drain("s2");

    // Redirect while streaming (pop of pc 5 coincides with the redirect)
    do_reset(1'b1);
    push_range(16'h0000, 6);
    push_range(16'h0100, 4);
    repeat (7) next_cycle();
    redirect_valid = 1'b1;
    redirect_pc = 16'h0100;
    @(negedge clk);
    chk("s3_redir_en", 32'(ic_rd_en), 32'd0);
    next_cycle();
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("s3_new_en", 32'(ic_rd_en), 32'd1);
    chk("s3_new_dest", 32'(ic_rd_dest), 32'h0100);
    next_cycle();
    @(negedge clk);
    chk("s3_gap_valid", 32'(dec_valid), 32'd0);
    next_cycle();
    @(negedge clk);
    chk("s3_ret_valid", 32'(dec_valid), 32'd1);
    chk("s3_ret_pc", 32'(dec_pc), 32'h0100);
    next_cycle();
    next_cycle();
    halt = 1'b1;
    drain("s3");

    // Redirect under halt to 16'hFFFE, then PC wrap-around
    redirect_valid = 1'b1;
    redirect_pc = 16'hFFFE;
    @(negedge clk);
    chk("s4_redir_en", 32'(ic_rd_en), 32'd0);
    next_cycle();
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("s4_halted_en", 32'(ic_rd_en), 32'd0);
    next_cycle();
    halt = 1'b0;
    for (int k = 0; k < 4; k++) exp_q.push_back(wrap_seq[k]);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("s4_wrap_en", 32'(ic_rd_en), 32'd1);
      chk("s4_wrap_dest", 32'(ic_rd_dest), 32'(wrap_seq[k]));
      next_cycle();
    end
    halt = 1'b1;
    drain("s4");

    // Reset mid-stream: outputs drop at once, restart cleanly
    do_reset(1'b1);
    push_range(16'h0000, 4);
    repeat (6) next_cycle();
    rst_n = 1'b0;
    #1;
    chk("s6_async_valid", 32'(dec_valid), 32'd0);
    chk("s6_async_en", 32'(ic_rd_en), 32'd0);
    chk("s6_async_pc", 32'(dec_pc), 32'h0);
    chk("s6_sb_empty", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    push_range(16'h0000, 4);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("s6_restart_en", 32'(ic_rd_en), 32'd1);
      chk("s6_restart_dest", 32'(ic_rd_dest), 32'(k));
      if (k < 2) chk("s6_no_stale", 32'(dec_valid), 32'd0);
      next_cycle();
    end
    halt = 1'b1;
    drain("s6");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
